// File: rtl/fap_task_tx.sv
// fap_task_tx: fragments a RAM-resident proof payload into FAP sub-frames on a 64-bit AXI-stream.
// Define FAP_TX_CHKSUM_EN to scan the payload first and carry its byte checksum in the last header.
module fap_task_tx #(
  parameter int SUB_WORDS = 128,
  parameter int LEN0      = 364,
  parameter int LEN1      = 636,
  parameter int AW        = 13
) (
  input  logic          clki,
  input  logic          rsti,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [7:0]    req_task_id,
  input  logic [7:0]    req_frm_type,
  input  logic [31:0]   req_fap_id,
  input  logic [AW-1:0] req_base,
  output logic [AW-1:0] mem_addr,
  input  logic [63:0]   mem_rdat,
  output logic [63:0]   tx_tdata,
  output logic [7:0]    tx_tkeep,
  output logic          tx_tlast,
  output logic          tx_tvalid,
  input  logic          tx_tready,
  output logic          done_o,
  output logic          err_o
);
  typedef enum logic [2:0] {IDLE, SCAN, HDR0, HDR1, PAY} state_t;
  state_t state_q, state_d;
  logic [7:0] task_q, task_d, type_q, type_d, sub_q, sub_d, rl_q, rl_d, bl_q, bl_d, hchk;
  logic [31:0] fap_q, fap_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [9:0] rem_q, rem_d;
  logic [63:0] b0_q, b0_d, b1_q, b1_d;
  logic [1:0] cnt_q, cnt_d, c;
  logic rv_q, rv_d, done_q, done_d, err_q, err_d, pop, rd, push;
`ifdef FAP_TX_CHKSUM_EN
  logic [7:0] chk_q, chk_d;
  logic [9:0] scn_q, scn_d;
  function automatic logic [7:0] bsum(input logic [63:0] w);
    bsum = 8'h00;
    for (int i = 0; i < 8; i++) bsum = bsum + w[8*i +: 8];
  endfunction
`endif
  function automatic logic [7:0] sub_len(input logic [9:0] r);
    return (r > 10'(SUB_WORDS)) ? 8'(SUB_WORDS) : r[7:0];
  endfunction
  function automatic logic [63:0] endian(input logic [63:0] w);
    return {<<8{w}};
  endfunction
  always_comb begin
    state_d = state_q;
    task_d = task_q;
    type_d = type_q;
    fap_d = fap_q;
    sub_d = sub_q;
    rem_d = rem_q;
    bl_d = bl_q;
    done_d = 1'b0;
    err_d = 1'b0;
    pop = state_q == PAY && tx_tready && cnt_q != 2'd0;
    // prefetch only while the skid buffer plus the in-flight read can still absorb a word
    rd = (state_q == HDR0 || state_q == HDR1 || state_q == PAY) && rl_q != 8'd0 &&
         (3'(cnt_q) + 3'(rv_q) - 3'(pop)) < 3'd2;
    rv_d = rd;
    rl_d = rl_q - 8'(rd);
    addr_d = addr_q + AW'(rd);
`ifdef FAP_TX_CHKSUM_EN
    chk_d = chk_q;
    scn_d = scn_q;
`endif
    case (state_q)
      IDLE: if (req_valid) begin
        task_d = req_task_id;
        type_d = req_frm_type;
        fap_d = req_fap_id;
        sub_d = 8'd0;
        addr_d = req_base;
        rem_d = req_frm_type[0] ? 10'(LEN1) : 10'(LEN0);
        rl_d = sub_len(rem_d);
        bl_d = rl_d;
`ifdef FAP_TX_CHKSUM_EN
        chk_d = 8'h00;
        scn_d = 10'd0;
        state_d = req_frm_type > 8'd1 ? IDLE : SCAN;
`else
        state_d = req_frm_type > 8'd1 ? IDLE : HDR0;
`endif
        err_d = req_frm_type > 8'd1;
      end
`ifdef FAP_TX_CHKSUM_EN
      SCAN: begin
        rv_d = scn_q < rem_q;
        addr_d = addr_q + AW'(rv_d);
        scn_d = scn_q + 10'd1;
        if (rv_q) chk_d = chk_q + bsum(mem_rdat);
        if (scn_q == rem_q + 10'd1) begin
          state_d = HDR0;
          addr_d = addr_q - AW'(rem_q);
        end
      end
`endif
      HDR0: if (tx_tready) state_d = HDR1;
      HDR1: if (tx_tready) state_d = PAY;
      PAY: if (pop) begin
        bl_d = bl_q - 8'd1;
        rem_d = rem_q - 10'd1;
        if (bl_q == 8'd1) begin
          done_d = rem_q == 10'd1;
          state_d = rem_q == 10'd1 ? IDLE : HDR0;
          sub_d = sub_q + 8'd1;
          rl_d = sub_len(rem_d);
          bl_d = rl_d;
        end
      end
      default: ;
    endcase
    push = rv_q && state_q != SCAN;
    c = cnt_q - 2'(pop);
    b0_d = pop ? b1_q : b0_q;
    b1_d = b1_q;
    if (push && c == 2'd0) b0_d = mem_rdat;
    if (push && c != 2'd0) b1_d = mem_rdat;
    cnt_d = c + 2'(push);
  end
  always_ff @(posedge clki or posedge rsti) begin
    if (rsti) begin
      state_q <= IDLE;
      task_q <= '0;
      type_q <= '0;
      fap_q <= '0;
      sub_q <= '0;
      rem_q <= '0;
      rl_q <= '0;
      bl_q <= '0;
      addr_q <= '0;
      b0_q <= '0;
      b1_q <= '0;
      cnt_q <= '0;
      rv_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      task_q <= task_d;
      type_q <= type_d;
      fap_q <= fap_d;
      sub_q <= sub_d;
      rem_q <= rem_d;
      rl_q <= rl_d;
      bl_q <= bl_d;
      addr_q <= addr_d;
      b0_q <= b0_d;
      b1_q <= b1_d;
      cnt_q <= cnt_d;
      rv_q <= rv_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
`ifdef FAP_TX_CHKSUM_EN
  always_ff @(posedge clki or posedge rsti) begin
    if (rsti) begin
      chk_q <= '0;
      scn_q <= '0;
    end else begin
      chk_q <= chk_d;
      scn_q <= scn_d;
    end
  end
  assign hchk = rem_q <= 10'(SUB_WORDS) ? chk_q : 8'h00;
`else
  assign hchk = 8'h00;
`endif
  assign req_ready = state_q == IDLE;
  assign mem_addr = addr_q;
  assign tx_tkeep = 8'hff;
  assign tx_tvalid = state_q == HDR0 || state_q == HDR1 || (state_q == PAY && cnt_q != 2'd0);
  assign tx_tlast = state_q == PAY && bl_q == 8'd1;
  assign tx_tdata = state_q == HDR0 ? endian({fap_q, 8'h01, 8'h04, 16'h0000}) :
                    state_q == HDR1 ? endian({task_q, hchk, type_q, sub_q, 32'h0}) :
                    state_q == PAY  ? endian(b0_q) : 64'h0;
  assign done_o = done_q;
  assign err_o = err_q;
endmodule

// File: tb/tb_fap_task_tx.sv
// tb_fap_task_tx: directed bench for fap_task_tx with a synchronous-read RAM model.
module tb_fap_task_tx;
  logic clki = 1'b0, rsti = 1'b0, req_valid = 1'b0, tx_tready = 1'b1;
  logic [7:0] req_task_id = 8'h0, req_frm_type = 8'h0;
  logic [31:0] req_fap_id = 32'h0;
  logic [12:0] req_base = 13'h0, mem_addr;
  logic [63:0] mem_rdat, tx_tdata;
  logic [7:0] tx_tkeep;
  logic tx_tlast, tx_tvalid, req_ready, done_o, err_o;
  logic [63:0] ram [0:8191];
  int n_cmp = 0, n_bad = 0;
`ifdef FAP_TX_CHKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  fap_task_tx dut (
    .clki(clki), .rsti(rsti), .req_valid(req_valid), .req_ready(req_ready),
    .req_task_id(req_task_id), .req_frm_type(req_frm_type), .req_fap_id(req_fap_id),
    .req_base(req_base), .mem_addr(mem_addr), .mem_rdat(mem_rdat), .tx_tdata(tx_tdata),
    .tx_tkeep(tx_tkeep), .tx_tlast(tx_tlast), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .done_o(done_o), .err_o(err_o)
  );
  always #5 clki = ~clki;
  always @(posedge clki) mem_rdat <= ram[mem_addr];
  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] endian(input logic [63:0] x);
    for (int i = 0; i < 8; i++) endian[8*i +: 8] = x[8*(7-i) +: 8];
  endfunction
  task automatic fill(input bit idx);
    for (int i = 0; i < 8192; i++) ram[i] = idx ? 64'(i) : 64'h0101010101010101;
  endtask
  task automatic run_task(input logic [7:0] tid, input logic [7:0] ft, input logic [31:0] fid,
                          input logic [12:0] base, input logic [7:0] xchk, input bit tog);
    logic [64:0] exp_q[$];
    logic [64:0] got_q[$];
    logic [64:0] prev;
    int len, nsub, sl, lat, done_n, done_c, last_c;
    logic rdy;
    bit stall;
    len = ft == 8'd1 ? 636 : 364;
    nsub = (len + 127) / 128;
    for (int s = 0; s < nsub; s++) begin
      sl = (len - s*128) < 128 ? len - s*128 : 128;
      exp_q.push_back({1'b0, endian({fid, 8'h01, 8'h04, 16'h0000})});
      exp_q.push_back({1'b0, endian({tid, ((CHK_EN && s == nsub-1) ? xchk : 8'h00), ft, 8'(s), 32'h0})});
      for (int k = 0; k < sl; k++)
        exp_q.push_back({k == sl-1, endian(ram[13'(int'(base) + s*128 + k)])});
    end
    @(negedge clki);
    req_task_id = tid; req_frm_type = ft; req_fap_id = fid; req_base = base; req_valid = 1'b1;
    @(negedge clki);
    req_valid = 1'b0;
    lat = 0; done_n = 0; done_c = 0; last_c = 0; rdy = 1'b0; stall = 1'b0; prev = '0;
    for (int c = 1; c < 4000; c++) begin
      if (c > 1) @(negedge clki);
      tx_tready = tog ? c[0] : 1'b1;
      if (stall) check($sformatf("t%0h_hold_c%0d", tid, c), {tx_tvalid, tx_tlast, tx_tdata}, {1'b1, prev});
      if (tx_tvalid && lat == 0) lat = c;
      if (done_o) begin
        done_n++;
        if (done_c == 0) begin done_c = c; rdy = req_ready; end
      end
      if (tx_tvalid && tx_tready) begin got_q.push_back({tx_tlast, tx_tdata}); last_c = c; end
      stall = tx_tvalid && !tx_tready;
      prev = {tx_tlast, tx_tdata};
      if (done_c != 0 && c >= done_c + 2) break;
    end
    tx_tready = 1'b1;
    check($sformatf("t%0h_latency", tid), 66'(lat), 66'(CHK_EN ? len + 3 : 1));
    check($sformatf("t%0h_beats", tid), 66'(got_q.size()), 66'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("t%0h_beat%0d", tid, i), 66'(got_q[i]), 66'(exp_q[i]));
      if (got_q[i] !== exp_q[i]) break;
    end
    check($sformatf("t%0h_done_pulses", tid), 66'(done_n), 66'd1);
    check($sformatf("t%0h_done_delay", tid), 66'(done_c - last_c), 66'd1);
    check($sformatf("t%0h_ready_at_done", tid), 66'(rdy), 66'd1);
    if (!tog) check($sformatf("t%0h_no_bubbles", tid), 66'(last_c - lat + 1), 66'(exp_q.size()));
  endtask
  initial begin
    int n;
    logic seen;
    fill(1'b0);
    #1 rsti = 1'b1;
    #2;
    check("rst_req_ready", 66'(req_ready), 66'd1);
    check("rst_tvalid", 66'(tx_tvalid), 66'd0);
    check("rst_tlast", 66'(tx_tlast), 66'd0);
    check("rst_tdata", 66'(tx_tdata), 66'd0);
    check("rst_mem_addr", 66'(mem_addr), 66'd0);
    check("rst_done", 66'(done_o), 66'd0);
    check("rst_err", 66'(err_o), 66'd0);
    check("tkeep", 66'(tx_tkeep), 66'hff);
    repeat (2) @(negedge clki);
    rsti = 1'b0;
    run_task(8'h05, 8'd1, 32'hDEADBEEF, 13'h0000, 8'hE0, 1'b0);
    run_task(8'h06, 8'd0, 32'hDEADBEEF, 13'h1FF0, 8'h60, 1'b0);
    fill(1'b1);
    run_task(8'h07, 8'd1, 32'h12345678, 13'h0000, 8'hC2, 1'b1);
    @(negedge clki);
    req_task_id = 8'h0A; req_frm_type = 8'h02; req_valid = 1'b1;
    @(negedge clki);
    req_valid = 1'b0;
    check("err_pulse", 66'(err_o), 66'd1);
    check("err_tvalid", 66'(tx_tvalid), 66'd0);
    check("err_ready", 66'(req_ready), 66'd1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clki);
      if (i == 0) check("err_clear", 66'(err_o), 66'd0);
      seen |= tx_tvalid;
    end
    check("err_no_beats", 66'(seen), 66'd0);
    @(negedge clki);
    req_task_id = 8'h08; req_frm_type = 8'd1; req_fap_id = 32'h0BADF00D; req_base = 13'h0; req_valid = 1'b1;
    @(negedge clki);
    req_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 3000 && n < 265; c++) begin
      if (tx_tvalid && tx_tready) n++;
      if (n < 265) @(negedge clki);
    end
    check("midrst_reached_sub2", 66'(n), 66'd265);
    #2 rsti = 1'b1;
    #1;
    check("midrst_tvalid", 66'(tx_tvalid), 66'd0);
    check("midrst_ready", 66'(req_ready), 66'd1);
    @(negedge clki);
    rsti = 1'b0;
    run_task(8'h09, 8'd0, 32'hCAFEF00D, 13'h1F80, 8'h92, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
